// File: rtl/counter_snapshot_fifo_pkg.sv
// Shared definitions for the counter snapshot FIFO slice.
//   DEFAULT_*   : default parameter values (snapshot width, FIFO depth,
//                 synchronizer length).
//   ptr_t       : read/write pointer type for the default depth.
//   lvl_t       : occupancy counter type for the default depth (0..DEPTH).
//   fifo_op_e   : per-cycle FIFO operation, encoded as {pop, push}.
package counter_snapshot_fifo_pkg;

  localparam int DEFAULT_WIDTH       = 8;
  localparam int DEFAULT_DEPTH       = 4;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef logic [$clog2(DEFAULT_DEPTH)-1:0] ptr_t;
  typedef logic [$clog2(DEFAULT_DEPTH):0]   lvl_t;

  // Bit 1 = effective pop, bit 0 = accepted push.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/counter_snapshot_fifo_if.sv
// Read-side bus of the snapshot FIFO.
//   pop, clr_ovf : reader -> FIFO strobes (pop head entry, clear overflow).
//   dout         : head entry, first-word fall-through, 0 when empty.
//   empty, full  : occupancy flags.
//   level        : number of stored entries.
//   overflow     : sticky "snapshot dropped while full" flag.
// master = reader, slave = FIFO.
interface counter_snapshot_fifo_if #(
  parameter int WIDTH = counter_snapshot_fifo_pkg::DEFAULT_WIDTH,
  parameter int DEPTH = counter_snapshot_fifo_pkg::DEFAULT_DEPTH
);

  logic                     pop;
  logic                     clr_ovf;
  logic [WIDTH-1:0]         dout;
  logic                     empty;
  logic                     full;
  logic [$clog2(DEPTH):0]   level;
  logic                     overflow;

  modport master (
    output pop, clr_ovf,
    input  dout, empty, full, level, overflow
  );

  modport slave (
    input  pop, clr_ovf,
    output dout, empty, full, level, overflow
  );

endinterface

// File: rtl/counter_snapshot_fifo_edge_sync.sv
// edge_sync: multi-flop synchronizer for an asynchronous input followed by a
// rising-edge detector. Reusable for any pin-level strobe (trigger, counter
// load).
//   clk, rst_n : clock, synchronous active-low reset (clears all flops).
//   d          : asynchronous level input.
//   pulse      : one-cycle pulse when the synchronized level goes 0 -> 1.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  // Clearing hist on reset means a level held high through reset still
  // yields exactly one pulse once the synchronizer refills.
  assign pulse = sync[SYNC_STAGES-1] & ~hist;

endmodule

// File: rtl/counter_snapshot_fifo.sv
// counter_snapshot_fifo: time-tags trigger events with the counter value.
// Each synchronized rising edge of trig pushes count_in into a small FIFO
// (while count_valid is high); the reader drains it through the rd bus.
//   clk, rst_n   : clock, synchronous active-low reset.
//   count_in     : current counter value (clk domain).
//   count_valid  : snapshots are only taken while high.
//   trig         : asynchronous event input.
//   rd           : read-side bus (pop, clr_ovf, dout, empty, full, level,
//                  overflow).
module counter_snapshot_fifo
  import counter_snapshot_fifo_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       count_in,
  input  logic                   count_valid,
  input  logic                   trig,
  counter_snapshot_fifo_if.slave rd
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic             overflow;

  logic             capture_req;
  logic             push;
  logic             do_pop;
  logic             accept;
  logic             drop;
  logic             empty;
  logic             full;
  fifo_op_e         op;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_trig_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (trig),
    .pulse (capture_req)
  );

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

  // A request with count_valid low is discarded outright: it neither pushes
  // nor counts as a drop.
  assign push   = capture_req & count_valid;
  assign do_pop = rd.pop & ~empty;
  // A simultaneous pop frees the slot a full FIFO needs for the push.
  assign accept = push & (~full | do_pop);
  assign drop   = push & full & ~do_pop;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    op = OP_NONE;
    case ({do_pop, accept})
      2'b01:   op = OP_PUSH;
      2'b10:   op = OP_POP;
      2'b11:   op = OP_BOTH;
      default: op = OP_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);

      case (op)
        OP_PUSH: level <= level + LW'(1);
        OP_POP:  level <= level - LW'(1);
        default: level <= level;
      endcase

      // Set has priority over clear so a drop in the clearing cycle is kept.
      if (drop)            overflow <= 1'b1;
      else if (rd.clr_ovf) overflow <= 1'b0;
    end
  end

  // NOTE: the storage array has no reset; it is only observable through
  // rd_ptr/level, which are reset, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (rst_n && accept) mem[wr_ptr] <= count_in;
  end

  assign rd.dout     = empty ? '0 : mem[rd_ptr];
  assign rd.empty    = empty;
  assign rd.full     = full;
  assign rd.level    = level;
  assign rd.overflow = overflow;

endmodule

// File: doc/counter_snapshot_fifo.md
# counter_snapshot_fifo

Downstream capture stage for the 8-bit free-running/loadable counter. On each rising edge of an external trigger it snapshots the current counter value into a small FIFO, which a reader drains one entry per pop. It turns the counter into a timestamp unit: pin-level events are time-tagged by counter value and read out at leisure over the bidirectional pins.

## Interface
Parameters:
- WIDTH, 8: snapshot width; equals counter width.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2: trigger synchronizer flops; at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- count_in  input  WIDTH  current counter value, registered in the clk domain.
- count_valid  input  1  counter output enable; snapshots are taken only while it is high.
- trig  input  1  asynchronous event input.
- pop  input  1  read strobe; removes the head entry.
- clr_ovf  input  1  clears the sticky overflow flag.
- dout  output  WIDTH  head entry (first-word fall-through); 0 when empty.
- empty  output  1  FIFO holds no entries.
- full  output  1  FIFO holds DEPTH entries.
- level  output  $clog2(DEPTH)+1  number of stored entries.
- overflow  output  1  sticky flag: at least one snapshot was dropped because the FIFO was full.

## Operation
- **Trigger path.** trig passes through a SYNC_STAGES-flop synchronizer, then one history flop. A capture request is raised when the synchronizer output is 1 and the history flop is 0 (rising edge).
- **Push.** A push occurs when a capture request is present and count_valid is 1. With count_valid low the request is discarded silently: no push, no overflow.
- **Storage.** DEPTH x WIDTH register array. Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The level counter is kept separately.
- **Pop.** A pop is effective only when empty is 0. Pop while empty is ignored and has no side effects.
- **Push and pop in the same cycle:**
  - Both happen; level is unchanged.
  - When full, the pop frees a slot, so the push is accepted and overflow is not set.
  - When empty, the pop is ignored and the push happens; level becomes 1.
- **Push while full without pop.** The snapshot is dropped and overflow is set to 1.
- **overflow clearing.** overflow stays set until clr_ovf=1 or reset. If clr_ovf and a new drop occur in the same cycle, overflow reads 1 afterwards (set wins).
- **Flags.** empty = (level==0) and full = (level==DEPTH), decoded from registered level.
- **dout.** dout = mem[rd_ptr] when not empty, else 0.
- **Reset** (synchronous, rst_n=0 at a clk edge):
  - Pointers, level, overflow and all synchronizer/history flops go to 0.
  - Memory contents are not reset.
  - Outputs after the reset edge: dout=0, empty=1, full=0, level=0, overflow=0.
  - Reset has priority over push, pop and clr_ovf.
  - A trig held high through reset produces exactly one capture after release.

## Timing
- **Trigger to storage.** trig first sampled high at edge k reaches the synchronizer output at edge k+SYNC_STAGES-1. The push happens at edge k+SYNC_STAGES, storing count_in as presented before that edge.
- **Push to visible.** The entry is visible on dout, with empty=0, after the push edge; no extra latency.
- **Pop.** At the pop edge, dout advances to the next entry, or to 0 if the FIFO becomes empty.
- **Throughput.** Maximum one push and one pop per cycle.
- **Back-to-back captures.** These need trig low for at least one sampled cycle between rising edges.
- **Level held high.** A trig level held high produces one capture only.

## Structure
- Shared package holds:
  - default WIDTH/DEPTH constants;
  - a ptr_t typedef, sized $clog2(DEPTH);
  - a lvl_t typedef, sized $clog2(DEPTH)+1.
- One sub-module, edge_sync: SYNC_STAGES synchronizer plus rising-edge pulse, with synchronous active-low reset. It is reusable for the counter's load input.
- The FIFO storage, pointer and flag logic live in counter_snapshot_fifo itself.

## Test plan
- **Reset.** Apply rst_n=0 for 2 cycles, with trig=0 -> dout=0, empty=1, full=0, level=0, overflow=0.
- **Single capture.** count_in=8'h2A, count_valid=1; trig rises, sampled high at edge k -> at edge k+2, level=1 and dout=8'h2A; pop one cycle -> empty=1, dout=0.
- **Fill and order.** Four trig pulses with count_in 8'h10, 8'h20, 8'h30, 8'h40 -> full=1, level=4; four pops -> dout sequence 10, 20, 30, 40; then empty=1.
- **Overflow.** Fill to 4 entries, then a fifth trig pulse -> level stays 4, overflow=1, contents unchanged. clr_ovf=1 for one cycle -> overflow=0.
- **Simultaneous events.**
  - Full FIFO, push and pop in the same cycle -> level=4, overflow=0, head advances, new value at tail.
  - Empty FIFO, push with pop -> level=1.
  - Pop while empty -> no change.
- **Gating and mid-operation reset.**
  - trig pulse with count_valid=0 -> no push, overflow=0.
  - Reset while level=3 with a trig pulse in flight -> all outputs at reset values.
  - Stale pulse not captured, because the synchronizer was cleared.
